e203_ifu_jalr_seq: RTL and testbench
====================================

// Module: e203_ifu_jalr_seq
// PURPOSE
//  IFU next-PC predictor and controller, fed by the mini-decoder outputs of the instruction being fetched.
//  Produces predicted-taken and target PC for JAL, JALR and Bxx; static prediction: backward Bxx is taken.
//  For JALR it sequences access to the jump base register rs1:
//   - waits out RAW hazards against in-flight writes (OITF, IR stage);
//   - borrows the regfile rs1 read port when the IR stage does not need it.
//  Stalls fetch with bpu_wait until the target is resolvable.
// PARAMETERS
//  PC_W     32  PC width
//  XLEN     32  data/immediate width
//  RFIDX_W  5   register index width
// PORTS
//  clk              in   1        core clock
//  rst_n            in   1        synchronous active-low reset
//  flush            in   1        pipeline flush; abandon any JALR sequence
//  pc               in   PC_W     PC of the decoded instruction
//  dec_i_valid      in   1        decoder outputs valid this cycle
//  dec_jal          in   1        instruction is JAL
//  dec_jalr         in   1        instruction is JALR
//  dec_bxx          in   1        instruction is a conditional branch
//  dec_bjp_imm      in   XLEN     sign-extended branch/jump offset
//  dec_jalr_rs1idx  in   RFIDX_W  JALR base register index
//  oitf_empty       in   1        no outstanding long-pipe writebacks
//  ir_valid         in   1        IR stage holds a valid instruction
//  ir_rs1en         in   1        IR instruction reads rs1 this cycle
//  ir_rden          in   1        IR instruction writes rd
//  ir_rdidx         in   RFIDX_W  IR instruction rd index
//  rf2bpu_x1        in   XLEN     dedicated x1 (ra) value
//  rf2bpu_rs1       in   XLEN     regfile rs1 port data, valid the cycle after bpu2rf_rs1_ena
//  bpu2rf_rs1_ena   out  1        claim rs1 read port, index = dec_jalr_rs1idx
//  bpu_wait         out  1        hold fetch; prediction not yet valid
//  prdt_taken       out  1        predicted taken
//  prdt_pc          out  PC_W     predicted target = op1 + dec_bjp_imm[PC_W-1:0], wrap mod 2^PC_W
// BEHAVIOUR
//  States IDLE, RS1_WAIT, RS1_READ. Registered state only; all outputs are combinational.
//  Reset: rst_n low at a clk edge -> state IDLE. While rst_n=0 all outputs are 0.
//  Outputs are meaningful only when dec_i_valid=1; with dec_i_valid=0 they are all 0 and state holds IDLE.
//  JAL:  taken=1, op1=pc, wait=0.
//  Bxx:  taken=dec_bjp_imm[XLEN-1], op1=pc, wait=0.
//  Other non-jump instructions: taken=0, prdt_pc=pc+imm (ignored), wait=0.
//  JALR op1 selection:
//   - rs1=x0: op1=0, wait=0.
//   - rs1=x1: op1=rf2bpu_x1. Hazard (x1dep) = ~oitf_empty | (ir_valid & ir_rden & ir_rdidx==1).
//     wait=x1dep; no FSM involvement.
//   - rs1=xN (N>1), handled by the FSM:
//     IDLE: dep = ~oitf_empty | (ir_valid & ir_rden & ir_rdidx==N);
//           busy = ir_valid & ir_rs1en.
//           dep|busy -> RS1_WAIT; else assert ena -> RS1_READ. wait=1.
//     RS1_WAIT: wait=1; when ~dep & ~busy, assert ena -> RS1_READ.
//     RS1_READ: op1=rf2bpu_rs1, wait=0, prediction valid -> IDLE.
//     Minimum latency: 1 cycle stall (ena cycle, then result cycle).
//  bpu2rf_rs1_ena is a single-cycle pulse, never asserted while ir_rs1en & ir_valid.
//  flush=1 dominates: state -> IDLE next edge, ena=0 and wait=0 in the flush cycle.
//  dec_i_valid dropping mid-sequence: -> IDLE, no ena.
//  Back-to-back JALRs: the 2nd restarts from IDLE the cycle after RS1_READ.
// CONFIGURATION
//  E203_IFU_JALR_X1_FAST_EN defined: x1 uses the dedicated rf2bpu_x1 path as above.
//  Not defined: x1 is treated as xN (FSM + read port); rf2bpu_x1 is unused.
// STRUCTURE
//  State encodings (2-bit IDLE=0, RS1_WAIT=1, RS1_READ=2) and PC_W/XLEN/RFIDX_W defaults
//   go in the shared e203_defines.v.
//  One sub-module: e203_ifu_jalr_dep (combinational dep/busy hazard check for a given index).
//  Adder and FSM live in the top.
// TESTING
//  JAL, pc=0x100, imm=0x20 -> taken=1, prdt_pc=0x120, wait=0, no ena.
//  Bxx, pc=0x200, imm=-8 -> taken=1, prdt_pc=0x1F8; imm=+8 -> taken=0.
//  JALR x5, idle pipe, rf2bpu_rs1=0x8000 after ena, imm=4
//   -> ena 1 cycle, wait 1 cycle, then prdt_pc=0x8004, taken=1.
//  JALR x5, IR writes x5 for 3 cycles -> wait=1, ena=0 for 3 cycles,
//   ena on the 4th, target on the 5th.
//  JALR x1 (FAST_EN), x1=0x3000, oitf_empty 0->1 after 2 cycles
//   -> wait 2 cycles, then prdt_pc=0x3000+imm; no ena ever.
//  flush in RS1_WAIT, and rst_n=0 in RS1_READ -> IDLE next edge, ena=0, outputs 0 during reset.

Source files
------------

// File: rtl/e203_ifu_jalr_seq_pkg.sv
// Shared types and default widths for the IFU next-PC predictor.
// Optional x1 fast path: define E203_IFU_JALR_X1_FAST_EN.
package e203_ifu_jalr_seq_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int XLEN_DEF    = 32;
    localparam int RFIDX_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RS1_WAIT = 2'd1,
        ST_RS1_READ = 2'd2
    } jalr_state_e;

    // True when a register index names the given architectural register.
    function automatic logic f_idx_is(input logic [RFIDX_W_DEF-1:0] idx,
                                      input logic [RFIDX_W_DEF-1:0] n);
        return (idx == n);
    endfunction

endpackage

// File: rtl/e203_ifu_jalr_dep.sv
// RAW-hazard and read-port-contention check for the JALR base register.
// Purely combinational; shared by the x1 fast path and the xN sequencer.
module e203_ifu_jalr_dep
    import e203_ifu_jalr_seq_pkg::*;
#(
    parameter int RFIDX_W = RFIDX_W_DEF
) (
    input  logic [RFIDX_W-1:0] idx,
    input  logic               oitf_empty,
    input  logic               ir_valid,
    input  logic               ir_rden,
    input  logic [RFIDX_W-1:0] ir_rdidx,
    input  logic               ir_rs1en,
    output logic               dep,
    output logic               busy
);

    logic w_ir_wr_hit;

    // An in-flight long-pipe write may target any register, so it is always a hazard.
    always_comb begin
        w_ir_wr_hit = ir_valid & ir_rden & (ir_rdidx == idx);
        dep         = (~oitf_empty) | w_ir_wr_hit;
        busy        = ir_valid & ir_rs1en;
    end

endmodule

// File: rtl/e203_ifu_jalr_seq.sv
// IFU next-PC predictor: static JAL/JALR/Bxx prediction and JALR rs1 sequencing.
// Optional x1 fast path: define E203_IFU_JALR_X1_FAST_EN.
module e203_ifu_jalr_seq
    import e203_ifu_jalr_seq_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int XLEN    = XLEN_DEF,
    parameter int RFIDX_W = RFIDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [PC_W-1:0]    pc,
    input  logic               dec_i_valid,
    input  logic               dec_jal,
    input  logic               dec_jalr,
    input  logic               dec_bxx,
    input  logic [XLEN-1:0]    dec_bjp_imm,
    input  logic [RFIDX_W-1:0] dec_jalr_rs1idx,
    input  logic               oitf_empty,
    input  logic               ir_valid,
    input  logic               ir_rs1en,
    input  logic               ir_rden,
    input  logic [RFIDX_W-1:0] ir_rdidx,
    input  logic [XLEN-1:0]    rf2bpu_x1,
    input  logic [XLEN-1:0]    rf2bpu_rs1,
    output logic               bpu2rf_rs1_ena,
    output logic               bpu_wait,
    output logic               prdt_taken,
    output logic [PC_W-1:0]    prdt_pc
);

`ifdef E203_IFU_JALR_X1_FAST_EN
    localparam logic X1_FAST = 1'b1;
`else
    localparam logic X1_FAST = 1'b0;
`endif

    jalr_state_e r_state;

    logic            w_dep;
    logic            w_busy;
    logic            w_hold;
    logic            w_is_x0;
    logic            w_is_x1;
    logic            w_x1_path;
    logic            w_dec_v;
    logic            w_jalr_v;
    logic            w_fsm_jalr;
    logic            w_can_issue;
    logic [PC_W-1:0] w_op1;

    e203_ifu_jalr_dep #(
        .RFIDX_W (RFIDX_W)
    ) u_dep (
        .idx        (dec_jalr_rs1idx),
        .oitf_empty (oitf_empty),
        .ir_valid   (ir_valid),
        .ir_rden    (ir_rden),
        .ir_rdidx   (ir_rdidx),
        .ir_rs1en   (ir_rs1en),
        .dep        (w_dep),
        .busy       (w_busy)
    );

    // Classify the decoded instruction; rst_n gates everything so outputs idle at 0 in reset.
    always_comb begin
        w_dec_v     = rst_n & dec_i_valid;
        w_jalr_v    = w_dec_v & dec_jalr;
        w_is_x0     = (dec_jalr_rs1idx == {RFIDX_W{1'b0}});
        w_is_x1     = (dec_jalr_rs1idx == RFIDX_W'(1));
        w_x1_path   = X1_FAST & w_is_x1;
        w_fsm_jalr  = w_jalr_v & ~w_is_x0 & ~w_x1_path;
        w_hold      = w_dep | w_busy;
        w_can_issue = (r_state == ST_IDLE) || (r_state == ST_RS1_WAIT);
    end

    // Read-port claim and fetch stall; flush silences both in its own cycle.
    always_comb begin
        bpu2rf_rs1_ena = w_fsm_jalr & ~flush & ~w_hold & w_can_issue;
        if (!w_jalr_v || flush) begin
            bpu_wait = 1'b0;
        end else if (w_is_x0) begin
            bpu_wait = 1'b0;
        end else if (w_x1_path) begin
            bpu_wait = w_dep;
        end else begin
            bpu_wait = (r_state != ST_RS1_READ);
        end
    end

    // Target operand select and adder; the immediate's upper bits drop out mod 2^PC_W.
    always_comb begin
        if (!w_jalr_v) begin
            w_op1 = pc;
        end else if (w_is_x0) begin
            w_op1 = {PC_W{1'b0}};
        end else if (w_x1_path) begin
            w_op1 = rf2bpu_x1[PC_W-1:0];
        end else begin
            w_op1 = rf2bpu_rs1[PC_W-1:0];
        end
        prdt_taken = w_dec_v & (dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[XLEN-1]));
        if (w_dec_v) begin
            prdt_pc = w_op1 + dec_bjp_imm[PC_W-1:0];
        end else begin
            prdt_pc = {PC_W{1'b0}};
        end
    end

    // JALR xN sequencer; any abandonment (reset, flush, decode drop) returns to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (flush || !w_fsm_jalr) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hold) begin
                        r_state <= ST_RS1_WAIT;
                    end else begin
                        r_state <= ST_RS1_READ;
                    end
                end
                ST_RS1_WAIT: begin
                    if (w_hold) begin
                        r_state <= ST_RS1_WAIT;
                    end else begin
                        r_state <= ST_RS1_READ;
                    end
                end
                ST_RS1_READ: r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e203_ifu_jalr_seq.sv
// Directed table-driven bench for e203_ifu_jalr_seq plus multi-cycle JALR sequences.
module tb_e203_ifu_jalr_seq;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] pc;
    logic        dec_i_valid;
    logic        dec_jal;
    logic        dec_jalr;
    logic        dec_bxx;
    logic [31:0] dec_bjp_imm;
    logic [4:0]  dec_jalr_rs1idx;
    logic        oitf_empty;
    logic        ir_valid;
    logic        ir_rs1en;
    logic        ir_rden;
    logic [4:0]  ir_rdidx;
    logic [31:0] rf2bpu_x1;
    logic [31:0] rf2bpu_rs1;
    logic        bpu2rf_rs1_ena;
    logic        bpu_wait;
    logic        prdt_taken;
    logic [31:0] prdt_pc;

    int n_checks;
    int n_fail;

    e203_ifu_jalr_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .pc              (pc),
        .dec_i_valid     (dec_i_valid),
        .dec_jal         (dec_jal),
        .dec_jalr        (dec_jalr),
        .dec_bxx         (dec_bxx),
        .dec_bjp_imm     (dec_bjp_imm),
        .dec_jalr_rs1idx (dec_jalr_rs1idx),
        .oitf_empty      (oitf_empty),
        .ir_valid        (ir_valid),
        .ir_rs1en        (ir_rs1en),
        .ir_rden         (ir_rden),
        .ir_rdidx        (ir_rdidx),
        .rf2bpu_x1       (rf2bpu_x1),
        .rf2bpu_rs1      (rf2bpu_rs1),
        .bpu2rf_rs1_ena  (bpu2rf_rs1_ena),
        .bpu_wait        (bpu_wait),
        .prdt_taken      (prdt_taken),
        .prdt_pc         (prdt_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic        jal;
        logic        jalr;
        logic        bxx;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic        oitf_empty;
        logic        ir_valid;
        logic        ir_rden;
        logic [4:0]  ir_rdidx;
        logic        ir_rs1en;
        logic        e_taken;
        logic [31:0] e_pc;
        logic        chk_pc;
        logic        e_wait;
        logic        e_ena;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic jal, input logic jalr, input logic bxx,
                         input logic [31:0] p, input logic [31:0] imm, input logic [4:0] rs1,
                         input logic oe, input logic irv, input logic irrd,
                         input logic [4:0] irrdidx, input logic irrs1);
        dec_i_valid     = v;
        dec_jal         = jal;
        dec_jalr        = jalr;
        dec_bxx         = bxx;
        pc              = p;
        dec_bjp_imm     = imm;
        dec_jalr_rs1idx = rs1;
        oitf_empty      = oe;
        ir_valid        = irv;
        ir_rden         = irrd;
        ir_rdidx        = irrdidx;
        ir_rs1en        = irrs1;
    endtask

    task automatic chk_out(input string name, input logic e_taken, input logic [31:0] e_pc,
                           input logic chk_pc, input logic e_wait, input logic e_ena);
        chk({name, ".taken"}, {31'd0, prdt_taken}, {31'd0, e_taken});
        if (chk_pc) chk({name, ".pc"}, prdt_pc, e_pc);
        chk({name, ".wait"}, {31'd0, bpu_wait}, {31'd0, e_wait});
        chk({name, ".ena"}, {31'd0, bpu2rf_rs1_ena}, {31'd0, e_ena});
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        flush = 1'b0;
    endtask

    // JALR x5 from a clean pipe: one ena+wait cycle, then the rs1 result.
    task automatic jalr_x5_step(input string name, input logic e_wait, input logic e_ena,
                                input logic [31:0] e_pc, input logic chk_pc);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 32'h4, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        chk_out(name, 1'b1, e_pc, chk_pc, e_wait, e_ena);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        flush      = 1'b0;
        rst_n      = 1'b0;
        rf2bpu_x1  = 32'h0;
        rf2bpu_rs1 = 32'h0;

        //          name       v     jal   jalr  bxx   pc            imm           rs1   oe    irv   rden  rdidx irs1  taken e_pc          cpc   wait  ena
        vecs[0]  = '{"jal",    1'b1, 1'b1, 1'b0, 1'b0, 32'h100,      32'h20,       5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h120,      1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"bxx_bwd",1'b1, 1'b0, 1'b0, 1'b1, 32'h200,      32'hFFFFFFF8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h1F8,      1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"bxx_fwd",1'b1, 1'b0, 1'b0, 1'b1, 32'h200,      32'h8,        5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h208,      1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"nonjmp", 1'b1, 1'b0, 1'b0, 1'b0, 32'h300,      32'h10,       5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h310,      1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"jalr_x0",1'b1, 1'b0, 1'b1, 1'b0, 32'h400,      32'h44,       5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 32'h44,       1'b1, 1'b0, 1'b0};
        vecs[5]  = '{"jalr_go",1'b1, 1'b0, 1'b1, 1'b0, 32'h400,      32'h4,        5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1};
        vecs[6]  = '{"jalr_bsy",1'b1,1'b0, 1'b1, 1'b0, 32'h400,      32'h4,        5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[7]  = '{"jalr_oth",1'b1,1'b0, 1'b1, 1'b0, 32'h400,      32'h4,        5'd5, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1};
        vecs[8]  = '{"jalr_oitf",1'b1,1'b0,1'b1, 1'b0, 32'h400,      32'h4,        5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[9]  = '{"jal_wrap",1'b1,1'b1, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h20,       5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h10,       1'b1, 1'b0, 1'b0};
        vecs[10] = '{"no_valid",1'b0,1'b1, 1'b0, 1'b0, 32'h100,      32'h20,       5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};

        // Reset with a live JAL on the decoder: everything must read 0.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        chk_out("reset", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].jal, vecs[i].jalr, vecs[i].bxx, vecs[i].pc, vecs[i].imm,
                  vecs[i].rs1, vecs[i].oitf_empty, vecs[i].ir_valid, vecs[i].ir_rden,
                  vecs[i].ir_rdidx, vecs[i].ir_rs1en);
            #1;
            chk_out(vecs[i].name, vecs[i].e_taken, vecs[i].e_pc, vecs[i].chk_pc,
                    vecs[i].e_wait, vecs[i].e_ena);
            idle_cycle();
        end

        // JALR x5, clean pipe, rs1 = 0x8000.
        rf2bpu_rs1 = 32'h8000;
        jalr_x5_step("x5_c1", 1'b1, 1'b1, 32'h0, 1'b0);
        jalr_x5_step("x5_c2", 1'b0, 1'b0, 32'h8004, 1'b1);
        // Back-to-back: the same JALR restarts from IDLE.
        jalr_x5_step("b2b_c1", 1'b1, 1'b1, 32'h0, 1'b0);
        jalr_x5_step("b2b_c2", 1'b0, 1'b0, 32'h8004, 1'b1);
        idle_cycle();

        // JALR x5 while IR writes x5 for three cycles.
        rf2bpu_rs1 = 32'h9000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 32'h4, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
            #1;
            chk_out($sformatf("raw_c%0d", c + 1), 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        jalr_x5_step("raw_c4", 1'b1, 1'b1, 32'h0, 1'b0);
        jalr_x5_step("raw_c5", 1'b0, 1'b0, 32'h9004, 1'b1);
        idle_cycle();

        // JALR x1 with oitf busy for two cycles.
        rf2bpu_x1  = 32'h3000;
        rf2bpu_rs1 = 32'h5000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h600, 32'h10, 5'd1, (c >= 2), 1'b0, 1'b0, 5'd0, 1'b0);
            #1;
`ifdef E203_IFU_JALR_X1_FAST_EN
            if (c < 2) chk_out($sformatf("x1_c%0d", c + 1), 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
            else       chk_out($sformatf("x1_c%0d", c + 1), 1'b1, 32'h3010, 1'b1, 1'b0, 1'b0);
`else
            if (c < 2)       chk_out($sformatf("x1_c%0d", c + 1), 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
            else if (c == 2) chk_out("x1_c3", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
            else             chk_out("x1_c4", 1'b1, 32'h5010, 1'b1, 1'b0, 1'b0);
`endif
        end
        idle_cycle();

        // Flush while in RS1_WAIT, then the sequence restarts from IDLE.
        rf2bpu_rs1 = 32'h8000;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 32'h4, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
        #1;
        chk_out("fl_c1", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 32'h4, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_c2.wait", {31'd0, bpu_wait}, 32'd0);
        chk("fl_c2.ena", {31'd0, bpu2rf_rs1_ena}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk_out("fl_c3", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
        idle_cycle();

        // Decode drop while in RS1_WAIT.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 32'h4, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
        #1;
        chk_out("drop_c1", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        dec_i_valid = 1'b0;
        ir_valid    = 1'b0;
        ir_rs1en    = 1'b0;
        #1;
        chk_out("drop_c2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        jalr_x5_step("drop_c3", 1'b1, 1'b1, 32'h0, 1'b0);
        idle_cycle();

        // Reset asserted in RS1_READ.
        jalr_x5_step("rst_c1", 1'b1, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_out("rst_c2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("rst_c3", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
